// File: rtl/replenish_panel.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : replenish_panel
//  Purpose  : Vending-aisle service panel. Debounces aisle/mode switches,
//             tracks per-aisle stock during replenishment from keypad
//             amounts, and scans an 8-digit active-low 7-segment display.
//  Revision : 1.0  initial release
// ============================================================================
module replenish_panel #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SCAN_DIV        = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       chd1,
    input  logic       chd2,
    input  logic       chd3,
    input  logic       chd4,
    input  logic       csw1,
    input  logic       csw2,
    input  logic       csw3,
    input  logic [3:0] key_value,
    input  logic [7:0] in_S1_num,
    input  logic [7:0] in_S2_num,
    input  logic [7:0] in_S3_num,
    input  logic [7:0] in_S4_num,
    input  logic [7:0] in_S1_sell,
    input  logic [7:0] in_S2_sell,
    input  logic [7:0] in_S3_sell,
    input  logic [7:0] in_S4_sell,
    input  logic [7:0] price_sum,
    output logic [7:0] S1_num,
    output logic [7:0] S2_num,
    output logic [7:0] S3_num,
    output logic [7:0] S4_num,
    output logic [7:0] DIG,
    output logic [7:0] Y
);

    localparam int c_DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int c_DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_DEB_W-1:0] c_DEB_LAST = c_DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]         c_KEY_COMMIT = 4'd14;

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'd0,
        MODE_SOLD  = 2'd1,
        MODE_REP   = 2'd2,
        MODE_TOTAL = 2'd3
    } mode_t;

    // raw switch bundle: [3:0] aisle selects, [4] sold, [5] replenish, [6] total
    logic [6:0] w_raw;
    logic [6:0] r_sync1;
    logic [6:0] r_sync2;
    logic [6:0] w_deb;

    logic [7:0] r_num   [4];
    logic [7:0] w_in_num[4];
    logic [7:0] w_sell  [4];
    logic [8:0] w_sum   [4];

    logic       r_flag;
    logic       r_was_rep;
    logic [3:0] r_hd_prev;
    logic [3:0] w_hd_rise;
    mode_t      w_mode;
    logic       w_rep;

    logic [c_DIV_W-1:0] r_div;
    logic [2:0]         r_slot;
    logic [2:0]         w_slot_next;
    logic [7:0]         r_dig;
    logic [7:0]         r_y;
    logic [7:0]         w_dig_next;
    logic [7:0]         w_y_next;
    logic [1:0]         w_ch;
    logic [7:0]         w_val;
    logic [7:0]         w_mod;
    logic [3:0]         w_tens;
    logic [3:0]         w_ones;
    logic [3:0]         w_p_hund;
    logic [3:0]         w_p_tens;
    logic [3:0]         w_p_ones;
    logic [3:0]         w_digit;
    logic               w_blank;
    logic               w_dp;

    assign w_raw = {csw3, csw2, csw1, chd4, chd3, chd2, chd1};

    assign w_in_num[0] = in_S1_num;
    assign w_in_num[1] = in_S2_num;
    assign w_in_num[2] = in_S3_num;
    assign w_in_num[3] = in_S4_num;
    assign w_sell[0]   = in_S1_sell;
    assign w_sell[1]   = in_S2_sell;
    assign w_sell[2]   = in_S3_sell;
    assign w_sell[3]   = in_S4_sell;

    assign S1_num = r_num[0];
    assign S2_num = r_num[1];
    assign S3_num = r_num[2];
    assign S4_num = r_num[3];
    assign DIG    = r_dig;
    assign Y      = r_y;

    // two-flop synchronizer for every raw switch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // per-switch debouncer: follow the synchronized value only once it has
    // disagreed with the current output for DEBOUNCE_CYCLES clocks in a row
    for (genvar gi = 0; gi < 7; gi++) begin : g_deb
        logic [c_DEB_W-1:0] r_cnt;
        logic               r_bit;

        // restart the count whenever the input agrees with the output again
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_cnt <= '0;
                r_bit <= 1'b0;
            end else if (r_sync2[gi] == r_bit) begin
                r_cnt <= '0;
            end else if (r_cnt == c_DEB_LAST) begin
                r_cnt <= '0;
                r_bit <= r_sync2[gi];
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign w_deb[gi] = r_bit;
    end

    // mode decode, sold query has priority over replenish over total
    always_comb begin
        w_mode = MODE_IDLE;
        if (w_deb[4]) begin
            w_mode = MODE_SOLD;
        end else if (w_deb[5]) begin
            w_mode = MODE_REP;
        end else if (w_deb[6]) begin
            w_mode = MODE_TOTAL;
        end
    end

    assign w_rep     = (w_mode == MODE_REP);
    assign w_hd_rise = w_deb[3:0] & ~r_hd_prev;

    for (genvar gc = 0; gc < 4; gc++) begin : g_sum
        // nine bits so an oversized loaded stock can never wrap below 100
        assign w_sum[gc] = {1'b0, r_num[gc]} + {5'b0, key_value};
    end

    // stock registers: load on replenish entry, then add on aisle presses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                r_num[i] <= '0;
            end
            r_flag    <= 1'b0;
            r_was_rep <= 1'b0;
            r_hd_prev <= '0;
        end else begin
            r_was_rep <= w_rep;
            r_hd_prev <= w_deb[3:0];
            if (w_rep) begin
                r_flag <= (key_value == c_KEY_COMMIT);
                for (int i = 0; i < 4; i++) begin
                    if (!r_was_rep) begin
                        r_num[i] <= w_in_num[i];
                    end else if ((key_value != c_KEY_COMMIT) && w_hd_rise[i] &&
                                 (w_sum[i] < 9'd100)) begin
                        r_num[i] <= w_sum[i][7:0];
                    end
                end
            end else begin
                r_flag <= 1'b0;
            end
        end
    end

    // active-low 7-segment patterns, dp (bit 7) left dark
    function automatic logic [7:0] seg7(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    assign w_slot_next = r_slot - 3'd1;
    // slot pairs 7:6, 5:4, 3:2, 1:0 map to aisles 1..4
    assign w_ch        = ~w_slot_next[2:1];
    assign w_val       = (w_mode == MODE_SOLD) ? w_sell[w_ch] : r_num[w_ch];
    assign w_mod       = w_val % 8'd100;
    assign w_tens      = 4'(w_mod / 8'd10);
    assign w_ones      = 4'(w_mod % 8'd10);
    assign w_p_hund    = 4'(price_sum / 8'd100);
    assign w_p_tens    = 4'((price_sum / 8'd10) % 8'd10);
    assign w_p_ones    = 4'(price_sum % 8'd10);

    // content for the slot about to be shown, so DIG and Y change together
    always_comb begin
        w_digit = 4'd0;
        w_blank = 1'b1;
        w_dp    = 1'b0;
        case (w_mode)
            MODE_SOLD, MODE_REP: begin
                w_blank = 1'b0;
                w_digit = w_slot_next[0] ? w_tens : w_ones;
                w_dp    = w_rep && r_flag && (w_slot_next == 3'd0);
            end
            MODE_TOTAL: begin
                case (w_slot_next)
                    3'd2:    begin w_blank = 1'b0; w_digit = w_p_hund; end
                    3'd1:    begin w_blank = 1'b0; w_digit = w_p_tens; end
                    3'd0:    begin w_blank = 1'b0; w_digit = w_p_ones; end
                    default: w_blank = 1'b1;
                endcase
            end
            default: w_blank = 1'b1;
        endcase
        w_dig_next = (w_mode == MODE_IDLE) ? 8'hFF : ~(8'd1 << w_slot_next);
        w_y_next   = w_blank ? 8'hFF : seg7(w_digit);
        if (w_dp) begin
            w_y_next = w_y_next & 8'h7F;
        end
    end

    // scan divider and registered digit/segment outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div  <= '0;
            r_slot <= 3'd7;
            r_dig  <= 8'hFF;
            r_y    <= 8'hFF;
        end else if (r_div == c_DIV_LAST) begin
            r_div  <= '0;
            r_slot <= w_slot_next;
            r_dig  <= w_dig_next;
            r_y    <= w_y_next;
        end else begin
            r_div  <= r_div + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_replenish_panel.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_replenish_panel
//  Purpose  : Self-checking bench for replenish_panel: directed scenarios plus
//             randomized switch/keypad traffic against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_replenish_panel;

    localparam int DEB = 4;
    localparam int SD  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       chd1, chd2, chd3, chd4;
    logic       csw1, csw2, csw3;
    logic [3:0] key_value;
    logic [7:0] in_num [4];
    logic [7:0] in_sell[4];
    logic [7:0] price_sum;
    logic [7:0] s_num  [4];
    logic [7:0] DIG;
    logic [7:0] Y;

    always #5 clk = ~clk;

    replenish_panel #(
        .DEBOUNCE_CYCLES(DEB),
        .SCAN_DIV       (SD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .chd1      (chd1),
        .chd2      (chd2),
        .chd3      (chd3),
        .chd4      (chd4),
        .csw1      (csw1),
        .csw2      (csw2),
        .csw3      (csw3),
        .key_value (key_value),
        .in_S1_num (in_num[0]),
        .in_S2_num (in_num[1]),
        .in_S3_num (in_num[2]),
        .in_S4_num (in_num[3]),
        .in_S1_sell(in_sell[0]),
        .in_S2_sell(in_sell[1]),
        .in_S3_sell(in_sell[2]),
        .in_S4_sell(in_sell[3]),
        .price_sum (price_sum),
        .S1_num    (s_num[0]),
        .S2_num    (s_num[1]),
        .S3_num    (s_num[2]),
        .S4_num    (s_num[3]),
        .DIG       (DIG),
        .Y         (Y)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural reference ----------------
    logic [7:0] seg_tab[10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    bit [6:0]     m_dly[2];     // raw switch values seen 1 and 2 clocks ago
    bit [DEB-1:0] m_win[7];     // last DEB synchronized samples per switch
    bit [6:0]     m_deb;
    int           m_num[4];
    bit           m_flag;
    bit           m_was_rep;
    bit [3:0]     m_hd_prev;
    int           m_edges;
    logic [7:0]   m_dig;
    logic [7:0]   m_y;

    function automatic int mode_of(input bit [6:0] d);
        if (d[4]) return 1;       // sold
        if (d[5]) return 2;       // replenish
        if (d[6]) return 3;       // total
        return 0;
    endfunction

    task automatic model_reset();
        m_dly[0] = '0; m_dly[1] = '0;
        for (int j = 0; j < 7; j++) m_win[j] = '0;
        m_deb = '0;
        for (int i = 0; i < 4; i++) m_num[i] = 0;
        m_flag = 0; m_was_rep = 0; m_hd_prev = '0;
        m_edges = 0; m_dig = 8'hFF; m_y = 8'hFF;
    endtask

    task automatic model_display(input int mode, input int slot);
        int v, d, ch, p;
        if (mode == 0) begin
            m_dig = 8'hFF; m_y = 8'hFF;
            return;
        end
        m_dig = 8'hFF & ~(8'd1 << slot);
        if (mode == 3) begin
            p = price_sum;
            case (slot)
                2:       m_y = seg_tab[p / 100];
                1:       m_y = seg_tab[(p / 10) % 10];
                0:       m_y = seg_tab[p % 10];
                default: m_y = 8'hFF;
            endcase
        end else begin
            ch = (7 - slot) / 2;
            v  = ((mode == 1) ? int'(in_sell[ch]) : m_num[ch]) % 100;
            d  = (slot % 2 == 1) ? v / 10 : v % 10;
            m_y = seg_tab[d];
            if (mode == 2 && m_flag && slot == 0) m_y = m_y & 8'h7F;
        end
    endtask

    // what the DUT does at the coming rising edge, from current state+inputs
    task automatic model_step();
        bit [6:0] raw;
        bit [3:0] rise;
        int mode, k;
        raw  = {csw3, csw2, csw1, chd4, chd3, chd2, chd1};
        mode = mode_of(m_deb);
        rise = m_deb[3:0] & ~m_hd_prev;
        if (m_edges % SD == SD - 1)
            model_display(mode, 7 - (((m_edges + 1) / SD) % 8));
        if (mode == 2) begin
            k = key_value;
            if (!m_was_rep) begin
                for (int i = 0; i < 4; i++) m_num[i] = in_num[i];
            end else if (k != 14) begin
                for (int i = 0; i < 4; i++)
                    if (rise[i] && m_num[i] + k < 100) m_num[i] += k;
            end
            m_flag = (k == 14);
        end else begin
            m_flag = 0;
        end
        m_was_rep = (mode == 2);
        m_hd_prev = m_deb[3:0];
        for (int j = 0; j < 7; j++) begin
            m_win[j] = {m_win[j][DEB-2:0], m_dly[1][j]};
            if (m_win[j] == '1) m_deb[j] = 1'b1;
            else if (m_win[j] == '0) m_deb[j] = 1'b0;
        end
        m_dly[1] = m_dly[0];
        m_dly[0] = raw;
        m_edges++;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) check_val($sformatf("S%0d_num", i + 1), s_num[i], m_num[i]);
        check_val("DIG", DIG, m_dig);
        check_val("Y", Y, m_y);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_slot(input logic [7:0] pattern, input string tag);
        bit found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (m_dig == pattern) found = 1;
        end
        check_val(tag, found, 1);
    endtask

    task automatic pulse(input int ch);
        case (ch)
            1: chd1 = 1'b1;
            2: chd2 = 1'b1;
            3: chd3 = 1'b1;
            default: chd4 = 1'b1;
        endcase
        run(DEB + 4);
        chd1 = 1'b0; chd2 = 1'b0; chd3 = 1'b0; chd4 = 1'b0;
        run(DEB + 4);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) check_val($sformatf("rst_S%0d", i + 1), s_num[i], 0);
        check_val("rst_DIG", DIG, 8'hFF);
        check_val("rst_Y", Y, 8'hFF);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        {chd1, chd2, chd3, chd4, csw1, csw2, csw3} = '0;
        key_value = 4'd5;
        in_num  = '{8'd10, 8'd95, 8'd50, 8'd0};
        in_sell = '{8'd42, 8'd7, 8'd99, 8'd0};
        price_sum = 8'd237;
        model_reset();
        #2;
        do_reset();

        run(4);
        check_val("idle_dig", DIG, 8'hFF);

        // replenish entry load, then one add per press
        csw2 = 1'b1;
        run(10);
        check_val("load_s1", s_num[0], 10);
        pulse(1);
        check_val("add_s1", s_num[0], 15);

        // sum must stay below 100
        key_value = 4'd7;
        pulse(2);
        check_val("ovf_s2", s_num[1], 95);
        key_value = 4'd4;
        pulse(2);
        check_val("edge_s2", s_num[1], 99);

        // commit key blocks adds and lights dp on slot 0
        key_value = 4'd14;
        pulse(3);
        check_val("commit_s3", s_num[2], 50);
        wait_slot(8'hFE, "wait_slot0");
        check_val("dp_slot0", Y, 8'h40);
        key_value = 4'd3;
        pulse(3);
        check_val("add_s3", s_num[2], 53);

        // short glitch ignored
        chd1 = 1'b1;
        run(2);
        chd1 = 1'b0;
        run(DEB + 4);
        check_val("glitch_s1", s_num[0], 15);

        // sold has priority over replenish
        csw1 = 1'b1;
        run(DEB + 4);
        wait_slot(8'h7F, "wait_slot7");
        check_val("sold_s7", Y, 8'h99);

        // total query
        csw1 = 1'b0; csw2 = 1'b0; csw3 = 1'b1;
        run(DEB + 4);
        wait_slot(8'hFB, "wait_t2");
        check_val("total_s2", Y, 8'hA4);
        wait_slot(8'hFD, "wait_t1");
        check_val("total_s1", Y, 8'hB0);
        wait_slot(8'hFE, "wait_t0");
        check_val("total_s0", Y, 8'hF8);
        wait_slot(8'h7F, "wait_t7");
        check_val("total_s7", Y, 8'hFF);

        // reset mid-operation with a switch held; history must be discarded
        csw3 = 1'b0; csw2 = 1'b1;
        run(12);
        do_reset();
        run(30);
        csw2 = 1'b0;
        run(20);
        check_val("idle_after", DIG, 8'hFF);

        // randomized traffic
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 3))
                    0: chd1 = ~chd1;
                    1: chd2 = ~chd2;
                    2: chd3 = ~chd3;
                    default: chd4 = ~chd4;
                endcase
            end
            if ($urandom_range(0, 59) == 0) begin
                case ($urandom_range(0, 2))
                    0: csw1 = ~csw1;
                    1: csw2 = ~csw2;
                    default: csw3 = ~csw3;
                endcase
            end
            if ($urandom_range(0, 5) == 0)
                key_value = ($urandom_range(0, 3) == 0) ? 4'd14 : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 29) == 0) begin
                for (int i = 0; i < 4; i++) begin
                    in_num[i]  = 8'($urandom_range(0, 120));
                    in_sell[i] = 8'($urandom_range(0, 99));
                end
                price_sum = 8'($urandom_range(0, 255));
            end
            if (c == 1200) do_reset();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
